// File: rtl/gemm_ctrl_pkg.sv
// rtl/gemm_ctrl_pkg.sv - shared types for the GeMM tile scheduler
package gemm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Width-independent part of the per-beat tag; the top adds c_addr at AddrWidth.
  typedef struct packed {
    logic first;
    logic last;
  } tag_flags_t;

endpackage

// File: rtl/gemm_loop_counter.sv
// rtl/gemm_loop_counter.sv - wrap-around tile loop counter with enable and clear
module gemm_loop_counter #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] size_i,
  output logic [Width-1:0] count_o,
  output logic             last_o,
  output logic             wrap_o
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= last_o ? '0 : r_count + Width'(1);
    end
  end

  assign count_o = r_count;
  assign last_o  = (r_count == size_i - Width'(1));
  assign wrap_o  = en_i && last_o;

endmodule

// File: rtl/gemm_tile_scheduler.sv
// rtl/gemm_tile_scheduler.sv - output-stationary GeMM tile loop sequencer
// Issues A/B tile addresses, delays tags to the PE inputs and emits C writes.
module gemm_tile_scheduler
  import gemm_ctrl_pkg::*;
#(
  parameter int SizeAddrWidth = 8,
  parameter int AddrWidth     = 16,
  parameter int ReadLatency   = 1,
  parameter int PeLatency     = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     stall_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic                     issue_valid_o,
  output logic                     pe_valid_o,
  output logic                     pe_first_o,
  output logic                     pe_last_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef struct packed {
    tag_flags_t           flags;
    logic [AddrWidth-1:0] c_addr;
  } tag_t;

  state_e                   r_state, w_state_nxt;
  logic [SizeAddrWidth-1:0] r_m, r_n, r_k;
  logic [SizeAddrWidth-1:0] w_mt, w_nt, w_kt;
  logic                     w_kt_last, w_kt_wrap, w_nt_last, w_nt_wrap, w_mt_last, w_mt_wrap;
  logic                     w_start, w_zero, w_issue, w_final, w_pending;
  logic [AddrWidth-1:0]     w_mt_a, w_nt_a, w_kt_a, w_n_a, w_k_a;
  tag_t                     w_tag;
  tag_t                     r_rd_tag  [ReadLatency];
  logic                     r_rd_vld  [ReadLatency];
  logic                     r_wr_we   [PeLatency];
  logic [AddrWidth-1:0]     r_wr_addr [PeLatency];

  assign w_start = (r_state == ST_IDLE) && start_i;
  assign w_zero  = (M_size_i == '0) || (N_size_i == '0) || (K_size_i == '0);
  assign w_issue = (r_state == ST_RUN) && !stall_i;
  assign w_final = w_mt_wrap && w_mt_last && w_nt_last && w_kt_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m <= '0;
      r_n <= '0;
      r_k <= '0;
    end else if (w_start) begin
      r_m <= M_size_i;
      r_n <= N_size_i;
      r_k <= K_size_i;
    end
  end

  // kt innermost, then nt, then mt; each stage steps on the inner wrap.
  gemm_loop_counter #(.Width(SizeAddrWidth)) u_kt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(w_start), .en_i(w_issue), .size_i(r_k),
    .count_o(w_kt), .last_o(w_kt_last), .wrap_o(w_kt_wrap));
  gemm_loop_counter #(.Width(SizeAddrWidth)) u_nt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(w_start), .en_i(w_kt_wrap), .size_i(r_n),
    .count_o(w_nt), .last_o(w_nt_last), .wrap_o(w_nt_wrap));
  gemm_loop_counter #(.Width(SizeAddrWidth)) u_mt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(w_start), .en_i(w_nt_wrap), .size_i(r_m),
    .count_o(w_mt), .last_o(w_mt_last), .wrap_o(w_mt_wrap));

  assign w_mt_a = AddrWidth'(w_mt);
  assign w_nt_a = AddrWidth'(w_nt);
  assign w_kt_a = AddrWidth'(w_kt);
  assign w_n_a  = AddrWidth'(r_n);
  assign w_k_a  = AddrWidth'(r_k);

  assign sram_a_addr_o      = w_mt_a * w_k_a + w_kt_a;
  assign sram_b_addr_o      = w_kt_a * w_n_a + w_nt_a;
  assign w_tag.flags.first  = (w_kt == '0);
  assign w_tag.flags.last   = w_kt_last;
  assign w_tag.c_addr       = w_mt_a * w_n_a + w_nt_a;
  assign issue_valid_o      = w_issue;

  // Delay lines never freeze: a stalled cycle simply enters as a bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) begin
        r_rd_vld[i] <= 1'b0;
        r_rd_tag[i] <= '0;
      end
      for (int i = 0; i < PeLatency; i++) begin
        r_wr_we[i]   <= 1'b0;
        r_wr_addr[i] <= '0;
      end
    end else begin
      r_rd_vld[0] <= w_issue;
      r_rd_tag[0] <= w_issue ? w_tag : '0;
      for (int i = 1; i < ReadLatency; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_tag[i] <= r_rd_tag[i-1];
      end
      r_wr_we[0]   <= r_rd_vld[ReadLatency-1] && r_rd_tag[ReadLatency-1].flags.last;
      r_wr_addr[0] <= r_rd_tag[ReadLatency-1].flags.last ? r_rd_tag[ReadLatency-1].c_addr : '0;
      for (int i = 1; i < PeLatency; i++) begin
        r_wr_we[i]   <= r_wr_we[i-1];
        r_wr_addr[i] <= r_wr_addr[i-1];
      end
    end
  end

  assign pe_valid_o    = r_rd_vld[ReadLatency-1];
  assign pe_first_o    = r_rd_tag[ReadLatency-1].flags.first;
  assign pe_last_o     = r_rd_tag[ReadLatency-1].flags.last;
  assign sram_c_we_o   = r_wr_we[PeLatency-1];
  assign sram_c_addr_o = r_wr_addr[PeLatency-1];

  always_comb begin
    w_pending = 1'b0;
    for (int i = 0; i < ReadLatency; i++) begin
      w_pending = w_pending | (r_rd_vld[i] & r_rd_tag[i].flags.last);
    end
    for (int i = 0; i < PeLatency - 1; i++) begin
      w_pending = w_pending | r_wr_we[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_i) w_state_nxt = w_zero ? ST_DONE : ST_RUN;
      ST_RUN:   if (w_final) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (sram_c_we_o && !w_pending) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o = (r_state != ST_IDLE);
  assign done_o = (r_state == ST_DONE);

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// tb/tb_gemm_tile_scheduler.sv - self-checking bench for gemm_tile_scheduler
module tb_gemm_tile_scheduler;

  localparam int SW = 8;
  localparam int AW = 16;
  localparam int RL = 1;
  localparam int PL = 1;

  logic          clk_i = 1'b0;
  logic          rst_i, start_i, stall_i;
  logic [SW-1:0] m_sz, k_sz, n_sz;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic          issue_v, pe_v, pe_f, pe_l, c_we, busy, done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk_i = ~clk_i;

  gemm_tile_scheduler #(
    .SizeAddrWidth(SW), .AddrWidth(AW), .ReadLatency(RL), .PeLatency(PL)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz),
    .sram_a_addr_o(a_addr), .sram_b_addr_o(b_addr), .issue_valid_o(issue_v),
    .pe_valid_o(pe_v), .pe_first_o(pe_f), .pe_last_o(pe_l),
    .sram_c_addr_o(c_addr), .sram_c_we_o(c_we), .busy_o(busy), .done_o(done)
  );

  typedef struct { int a; int b; int c; bit f; bit l; } iss_t;
  typedef struct { int cyc; bit f; bit l; } pe_t;
  typedef struct { int cyc; int c; } wr_t;

  iss_t iss_q[$];
  pe_t  pe_q[$];
  wr_t  wr_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, 32'(a_addr), 0);
    chk({tag, "_b"}, 32'(b_addr), 0);
    chk({tag, "_c"}, 32'(c_addr), 0);
    chk({tag, "_flags"}, 32'({issue_v, pe_v, pe_f, pe_l, c_we, busy, done}), 0);
  endtask

  // stall_mode: 0 none, 1 every other cycle, 2 random
  task automatic run_job(input int m, input int n, input int k, input int stall_mode,
                         input bit hold, input int abort_after);
    int   t, done_cyc, issued;
    bit   exp_issue, exp_pe, exp_we;
    iss_t e;
    pe_t  p;
    wr_t  w;
    iss_q.delete(); pe_q.delete(); wr_q.delete();
    for (int mt = 0; mt < m; mt++)
      for (int nt = 0; nt < n; nt++)
        for (int kt = 0; kt < k; kt++) begin
          e.a = (mt * k + kt) % 65536;
          e.b = (kt * n + nt) % 65536;
          e.c = (mt * n + nt) % 65536;
          e.f = (kt == 0);
          e.l = (kt == k - 1);
          iss_q.push_back(e);
        end
    @(negedge clk_i); cyc++;
    m_sz = SW'(m); n_sz = SW'(n); k_sz = SW'(k);
    start_i = 1'b1; stall_i = 1'b0; t = cyc;
    #1;
    chk("idle_before_start", 32'(busy), 0);
    done_cyc = (m == 0 || n == 0 || k == 0) ? t + 1 : 32'h4000_0000;
    issued = 0;
    while (cyc < done_cyc + 2) begin
      @(negedge clk_i); cyc++;
      start_i = hold && (iss_q.size() > 0);
      if (hold) {m_sz, k_sz, n_sz} = 24'($urandom);
      case (stall_mode)
        1:       stall_i = cyc[0];
        2:       stall_i = ($urandom_range(0, 2) == 0);
        default: stall_i = 1'b0;
      endcase
      #1;
      exp_issue = (iss_q.size() > 0) && !stall_i;
      chk("issue_valid", 32'(issue_v), 32'(exp_issue));
      if (exp_issue && issue_v) begin
        e = iss_q.pop_front();
        chk("a_addr", 32'(a_addr), e.a);
        chk("b_addr", 32'(b_addr), e.b);
        p.cyc = cyc + RL; p.f = e.f; p.l = e.l;
        pe_q.push_back(p);
        if (e.l) begin
          w.cyc = cyc + RL + PL; w.c = e.c;
          wr_q.push_back(w);
        end
        if (iss_q.size() == 0) done_cyc = cyc + RL + PL + 1;
        issued++;
      end
      exp_pe = (pe_q.size() > 0) && (pe_q[0].cyc == cyc);
      chk("pe_valid", 32'(pe_v), 32'(exp_pe));
      if (exp_pe) begin
        p = pe_q.pop_front();
        chk("pe_first", 32'(pe_f), 32'(p.f));
        chk("pe_last", 32'(pe_l), 32'(p.l));
      end
      exp_we = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
      chk("c_we", 32'(c_we), 32'(exp_we));
      if (exp_we) begin
        w = wr_q.pop_front();
        chk("c_addr", 32'(c_addr), w.c);
      end
      chk("done", 32'(done), 32'(cyc == done_cyc));
      chk("busy", 32'(busy), 32'(cyc <= done_cyc));
      if (abort_after > 0 && issued == abort_after) break;
      if (cyc - t > 4000) begin
        chk("job_timeout_remaining", 32'(iss_q.size()), 0);
        break;
      end
    end
    if (abort_after == 0) begin
      chk("all_beats_seen", 32'(pe_q.size() + wr_q.size() + iss_q.size()), 0);
    end
    start_i = 1'b0;
    stall_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
    m_sz = '0; n_sz = '0; k_sz = '0;
    repeat (3) begin @(negedge clk_i); cyc++; end
    #1;
    chk_all_zero("reset");
    rst_i = 1'b0;

    run_job(2, 2, 3, 0, 1'b0, 0);
    run_job(1, 4, 1, 0, 1'b0, 0);
    run_job(2, 2, 2, 1, 1'b0, 0);
    run_job(2, 0, 3, 0, 1'b0, 0);
    run_job(0, 3, 3, 2, 1'b0, 0);
    run_job(2, 3, 0, 0, 1'b0, 0);

    run_job(4, 4, 4, 0, 1'b0, 10);
    @(negedge clk_i); cyc++;
    rst_i = 1'b1;
    @(negedge clk_i); cyc++;
    #1;
    chk_all_zero("abort_reset");
    rst_i = 1'b0;
    repeat (12) begin
      @(negedge clk_i); cyc++;
      #1;
      chk("post_abort_quiet", 32'({issue_v, pe_v, c_we, busy, done}), 0);
    end
    run_job(2, 3, 2, 0, 1'b0, 0);

    run_job(3, 2, 2, 0, 1'b1, 0);
    run_job(2, 2, 3, 2, 1'b1, 0);

    for (int j = 0; j < 4; j++) begin
      run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
              int'($urandom_range(1, 4)), 2, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
